// File: rtl/ofm_addr_controller_pkg.sv
// Shared CNN geometry constants and the tile-controller state encoding,
// common to the IFM read and OFM write address controllers.
package ofm_addr_controller_pkg;

    localparam int CNN_SYSTOLIC_SIZE  = 16;
    localparam int CNN_NUM_FILTER     = 16;
    localparam int CNN_KERNEL_SIZE    = 3;
    localparam int CNN_IFM_SIZE       = 34;
    localparam int CNN_OFM_SIZE       = CNN_IFM_SIZE - CNN_KERNEL_SIZE + 1;
    localparam int CNN_OFM_ADDR_WIDTH = 14;
    localparam int CNN_SIZE_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_UPDATE = 2'd2
    } tile_state_t;

endpackage

// File: rtl/ofm_addr_controller_if.sv
// Scheduler <-> OFM write controller bundle: tile start/size in, write
// address/strobe/PE select and tile status out.
interface ofm_addr_controller_if
    import ofm_addr_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = CNN_OFM_ADDR_WIDTH,
    parameter int ROW_W      = $clog2(CNN_SYSTOLIC_SIZE),
    parameter int COL_W      = $clog2(CNN_NUM_FILTER)
);
    logic                  start;
    logic [CNN_SIZE_W-1:0] size;
    logic [ADDR_WIDTH-1:0] ofm_addr;
    logic                  write_en;
    logic [ROW_W-1:0]      pe_row;
    logic [COL_W-1:0]      pe_col;
    logic                  busy;
    logic                  tile_done;
    logic                  ofm_done;

    modport master (
        output start, size,
        input  ofm_addr, write_en, pe_row, pe_col, busy, tile_done, ofm_done
    );

    modport slave (
        input  start, size,
        output ofm_addr, write_en, pe_row, pe_col, busy, tile_done, ofm_done
    );
endinterface

// File: rtl/ofm_addr_controller_tile_position.sv
// OFM tile position tracker: walks down all rows of a strip, then steps one
// strip right; keeps row*OFM_SIZE+base_col incrementally as tile_base.
module ofm_addr_controller_tile_position #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 32,
    parameter int ADDR_WIDTH    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] tile_base,
    output logic                  ofm_last
);
    localparam int POS_W = $clog2(OFM_SIZE);

    logic [POS_W-1:0]      row_q;
    logic [POS_W-1:0]      col_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  last_row;
    logic                  strip_next;

    assign last_row   = (row_q == POS_W'(OFM_SIZE - 1));
    assign strip_next = ((int'(col_q) + SYSTOLIC_SIZE) < OFM_SIZE);
    assign ofm_last   = last_row && !strip_next;
    assign tile_base  = base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else if (advance) begin
            if (!last_row) begin
                row_q  <= row_q + 1'b1;
                base_q <= base_q + ADDR_WIDTH'(OFM_SIZE);
            end else if (strip_next) begin
                row_q  <= '0;
                col_q  <= col_q + POS_W'(SYSTOLIC_SIZE);
                base_q <= ADDR_WIDTH'(col_q) + ADDR_WIDTH'(SYSTOLIC_SIZE);
            end else begin
                row_q  <= '0;
                col_q  <= '0;
                base_q <= '0;
            end
        end
    end
endmodule

// File: rtl/ofm_addr_controller.sv
// OFM write address controller: drains one systolic tile into OFM memory,
// filter-major, one write per cycle with incrementally built addresses.
//   state     | meaning
//   ST_IDLE   | waiting for start; latches clamped tile size
//   ST_WRITE  | one OFM write per cycle, f outer / i inner
//   ST_UPDATE | tile_done pulse, advance tile position
module ofm_addr_controller
    import ofm_addr_controller_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = CNN_SYSTOLIC_SIZE,
    parameter int NUM_FILTER    = CNN_NUM_FILTER,
    parameter int OFM_SIZE      = CNN_OFM_SIZE,
    parameter int ADDR_WIDTH    = CNN_OFM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ofm_addr_controller_if.slave  bus
);
    localparam int ROW_W = $clog2(SYSTOLIC_SIZE);
    localparam int COL_W = $clog2(NUM_FILTER);
    localparam logic [ADDR_WIDTH-1:0] PLANE  = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE);
    localparam logic [CNN_SIZE_W-1:0] SZ_MAX = CNN_SIZE_W'(SYSTOLIC_SIZE);

    tile_state_t           state_q, state_d;
    logic [CNN_SIZE_W-1:0] sz_q, sz_d;
    logic [ROW_W-1:0]      i_q, i_d;
    logic [COL_W-1:0]      f_q, f_d;
    logic [ADDR_WIDTH-1:0] fbase_q, fbase_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  tdone_q, tdone_d;
    logic                  odone_q, odone_d;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] tile_base;
    logic                  ofm_last;
    logic [CNN_SIZE_W-1:0] size_clamped;
    logic                  last_pix;
    logic                  last_filt;

    ofm_addr_controller_tile_position #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .OFM_SIZE      (OFM_SIZE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .tile_base (tile_base),
        .ofm_last  (ofm_last)
    );

    assign size_clamped = (bus.size > SZ_MAX) ? SZ_MAX : bus.size;
    assign last_pix     = (CNN_SIZE_W'(i_q) == (sz_q - CNN_SIZE_W'(1)));
    assign last_filt    = (f_q == COL_W'(NUM_FILTER - 1));

    always_comb begin
        state_d = state_q;
        sz_d    = sz_q;
        i_d     = i_q;
        f_d     = f_q;
        fbase_d = fbase_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        tdone_d = 1'b0;
        odone_d = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sz_d   = size_clamped;
                    busy_d = 1'b1;
                    if (size_clamped == '0) begin
                        state_d = ST_UPDATE;
                        tdone_d = 1'b1;
                        odone_d = ofm_last;
                    end else begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        i_d     = '0;
                        f_d     = '0;
                        fbase_d = tile_base;
                        addr_d  = tile_base;
                    end
                end
            end
            ST_WRITE: begin
                // i_q/f_q describe the write currently on the outputs
                if (last_pix && last_filt) begin
                    state_d = ST_UPDATE;
                    tdone_d = 1'b1;
                    odone_d = ofm_last;
                    i_d     = '0;
                    f_d     = '0;
                end else if (last_pix) begin
                    we_d    = 1'b1;
                    i_d     = '0;
                    f_d     = f_q + 1'b1;
                    fbase_d = fbase_q + PLANE;
                    addr_d  = fbase_q + PLANE;
                end else begin
                    we_d    = 1'b1;
                    i_d     = i_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sz_q    <= '0;
            i_q     <= '0;
            f_q     <= '0;
            fbase_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            tdone_q <= 1'b0;
            odone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sz_q    <= sz_d;
            i_q     <= i_d;
            f_q     <= f_d;
            fbase_q <= fbase_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            tdone_q <= tdone_d;
            odone_q <= odone_d;
        end
    end

    assign bus.ofm_addr  = addr_q;
    assign bus.write_en  = we_q;
    assign bus.pe_row    = i_q;
    assign bus.pe_col    = f_q;
    assign bus.busy      = busy_q;
    assign bus.tile_done = tdone_q;
    assign bus.ofm_done  = odone_q;
endmodule

// File: tb/tb_ofm_addr_controller.sv
// Bench for ofm_addr_controller: two instances (OFM 32 and OFM 30) share one
// tile stream and are checked every cycle against an arithmetic tile model.
module tb_ofm_addr_controller;
    import ofm_addr_controller_pkg::*;

    bit        clk = 1'b0;
    logic      rst_n;
    logic      start;
    logic [4:0] size_in;

    int checks   = 0;
    int failures = 0;
    int mrow[2];
    int mcol[2];
    int hold[2];
    int osz[2] = '{32, 30};
    int tile_no = 0;

    always #5 clk = ~clk;

    ofm_addr_controller_if #(.ADDR_WIDTH(14), .ROW_W(4), .COL_W(4)) bus_a ();
    ofm_addr_controller_if #(.ADDR_WIDTH(14), .ROW_W(4), .COL_W(4)) bus_b ();

    assign bus_a.start = start;
    assign bus_a.size  = size_in;
    assign bus_b.start = start;
    assign bus_b.size  = size_in;

    ofm_addr_controller dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ofm_addr_controller #(.OFM_SIZE(30)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic chk_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic compare_dut(input int k, input string where, input int e_we,
                               input int e_addr, input int e_row, input int e_col,
                               input int e_td, input int e_od, input int e_busy);
        int a_we, a_addr, a_row, a_col, a_td, a_od, a_busy;
        if (k == 0) begin
            a_we = int'(bus_a.write_en); a_addr = int'(bus_a.ofm_addr);
            a_row = int'(bus_a.pe_row); a_col = int'(bus_a.pe_col);
            a_td = int'(bus_a.tile_done); a_od = int'(bus_a.ofm_done); a_busy = int'(bus_a.busy);
        end else begin
            a_we = int'(bus_b.write_en); a_addr = int'(bus_b.ofm_addr);
            a_row = int'(bus_b.pe_row); a_col = int'(bus_b.pe_col);
            a_td = int'(bus_b.tile_done); a_od = int'(bus_b.ofm_done); a_busy = int'(bus_b.busy);
        end
        chk_eq($sformatf("%s_d%0d_write_en", where, k), a_we, e_we);
        chk_eq($sformatf("%s_d%0d_ofm_addr", where, k), a_addr, e_addr);
        chk_eq($sformatf("%s_d%0d_pe_row", where, k), a_row, e_row);
        chk_eq($sformatf("%s_d%0d_pe_col", where, k), a_col, e_col);
        chk_eq($sformatf("%s_d%0d_tile_done", where, k), a_td, e_td);
        chk_eq($sformatf("%s_d%0d_ofm_done", where, k), a_od, e_od);
        chk_eq($sformatf("%s_d%0d_busy", where, k), a_busy, e_busy);
    endtask

    // Expected outputs for cycle n after start of a tile of sz pixels.
    task automatic check_cycle(input int n, input int sz);
        int total, idx, f, i, e_addr, e_td, e_od;
        total = sz * 16;
        for (int k = 0; k < 2; k++) begin
            e_td = (n == total + 1) ? 1 : 0;
            e_od = (e_td == 1 && mrow[k] == osz[k] - 1 && mcol[k] + 16 >= osz[k]) ? 1 : 0;
            if (n <= total) begin
                idx = n - 1;
                f = idx / sz;
                i = idx % sz;
                e_addr = f * osz[k] * osz[k] + mrow[k] * osz[k] + mcol[k] + i;
                hold[k] = e_addr;
                compare_dut(k, $sformatf("t%0d_c%0d", tile_no, n), 1, e_addr, i, f,
                            e_td, e_od, 1);
            end else begin
                compare_dut(k, $sformatf("t%0d_c%0d", tile_no, n), 0, hold[k], 0, 0,
                            e_td, e_od, (n <= total + 1) ? 1 : 0);
            end
        end
    endtask

    task automatic advance_model();
        for (int k = 0; k < 2; k++) begin
            if (mrow[k] < osz[k] - 1) begin
                mrow[k]++;
            end else if (mcol[k] + 16 < osz[k]) begin
                mrow[k] = 0;
                mcol[k] += 16;
            end else begin
                mrow[k] = 0;
                mcol[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mrow[k] = 0;
            mcol[k] = 0;
            hold[k] = 0;
        end
    endtask

    // ign_at: cycle at which a stray start is pulsed; rst_at: cycle to assert reset.
    task automatic run_tile(input int size, input int ign_at, input int rst_at);
        int sz;
        logic [4:0] size_v;
        tile_no++;
        sz = (size > 16) ? 16 : size;
        size_v = 5'(size);
        @(negedge clk);
        start = 1'b1;
        size_in = size_v;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= sz * 16 + 2; n++) begin
            check_cycle(n, sz);
            if (n == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                for (int k = 0; k < 2; k++)
                    compare_dut(k, $sformatf("t%0d_rst", tile_no), 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (n == ign_at) begin
                start = 1'b1;
                size_in = 5'($urandom_range(1, 20));
            end
            @(negedge clk);
            start = 1'b0;
        end
        advance_model();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        rst_n = 1'b0;
        start = 1'b1;
        size_in = 5'd16;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_eq($sformatf("rst_start_we_a_%0d", c), int'(bus_a.write_en), 0);
            chk_eq($sformatf("rst_start_we_b_%0d", c), int'(bus_b.write_en), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                compare_dut(k, $sformatf("idle%0d", c), 0, 0, 0, 0, 0, 0, 0);
        end

        for (int t = 1; t <= 66; t++) begin
            case (t)
                1, 2:    run_tile(16, -1, -1);
                3:       run_tile(0, -1, -1);
                4:       run_tile(20, -1, -1);
                5:       run_tile(1, -1, -1);
                6:       run_tile(16, 100, -1);
                7:       run_tile(16, 257, -1);
                33:      run_tile(16, -1, -1);
                34:      run_tile(14, -1, -1);
                default: begin
                    sz = int'($urandom_range(0, 20));
                    run_tile(sz, -1, -1);
                end
            endcase
        end

        run_tile(16, -1, 100);
        run_tile(16, -1, -1);
        run_tile(int'($urandom_range(0, 20)), -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
